keypad_scanner: RTL and testbench

KEYPAD_SCANNER -- requirements
Module: keypad_scanner

---
 rtl/keypad_scanner.sv | 132 +++++++++++++
 tb/tb_keypad_scanner.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner with whole-frame debounce; no backpressure, keys/key_valid update
// one cycle after the accepting frame boundary (press to key_valid <= (DEBOUNCE_FRAMES+1) frames).
module keypad_scanner #(
   parameter int SCAN_DIV        = 1000,
   parameter int DEBOUNCE_FRAMES = 8
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [3:0]  col_in,
   output logic [3:0]  row_out,
   output logic [15:0] keys,
   output logic [3:0]  key_code,
   output logic        key_valid,
   output logic        multi_err
);

   localparam int DW = $clog2(SCAN_DIV);
   localparam int SW = $clog2(DEBOUNCE_FRAMES + 1);
   localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);
   localparam logic [SW-1:0] STAB_MAX = SW'(DEBOUNCE_FRAMES);

   typedef enum logic [1:0] {IDLE, PRESSED, MULTI} state_t;

   logic [3:0]    col_s1, col_s2, col_act;
   logic [DW-1:0] div;
   logic [1:0]    row;
   logic [11:0]   frame_lo;
   logic [15:0]   snap, prev_snap;
   logic [SW-1:0] stab, stab_nxt;
   logic          slot_end, frame_end, accept;

   state_t        state, state_nxt;
   logic [15:0]   keys_nxt;
   logic [3:0]    code_nxt, snap_idx;
   logic          multi_nxt, valid_nxt;

   assign row_out   = ~(4'b0001 << row);
   assign col_act   = ~col_s2;
   assign slot_end  = (div == DIV_LAST);
   assign frame_end = slot_end && (row == 2'd3);
   // Row 3 is never stored: its sample completes the snapshot directly.
   assign snap      = {col_act, frame_lo};

   always_comb begin
      stab_nxt = stab;
      if (snap != prev_snap)
         stab_nxt = SW'(1);
      else if (stab != STAB_MAX)
         stab_nxt = stab + SW'(1);
   end

   assign accept = frame_end && (stab_nxt == STAB_MAX) && (stab != STAB_MAX);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         col_s1    <= 4'hF;
         col_s2    <= 4'hF;
         div       <= '0;
         row       <= 2'd0;
         frame_lo  <= '0;
         prev_snap <= '0;
         stab      <= '0;
      end else begin
         col_s1 <= col_in;
         col_s2 <= col_s1;
         if (slot_end) begin
            div <= '0;
            row <= row + 2'd1;
            case (row)
               2'd0:    frame_lo[3:0]  <= col_act;
               2'd1:    frame_lo[7:4]  <= col_act;
               2'd2:    frame_lo[11:8] <= col_act;
               default: ;
            endcase
         end else begin
            div <= div + DW'(1);
         end
         if (frame_end) begin
            prev_snap <= snap;
            stab      <= stab_nxt;
         end
      end
   end

   always_comb begin
      snap_idx = 4'd0;
      for (int i = 0; i < 16; i++)
         if (snap[i]) snap_idx = 4'(i);
   end

   always_comb begin
      state_nxt = state;
      keys_nxt  = keys;
      code_nxt  = key_code;
      multi_nxt = multi_err;
      valid_nxt = 1'b0;
      if (accept) begin
         if (snap == 16'h0000) begin
            state_nxt = IDLE;
            keys_nxt  = 16'h0000;
            multi_nxt = 1'b0;
         end else if ((snap & (snap - 16'd1)) == 16'h0000) begin
            state_nxt = PRESSED;
            keys_nxt  = snap;
            code_nxt  = snap_idx;
            multi_nxt = 1'b0;
            valid_nxt = (snap != keys);
         end else begin
            // Ambiguous chord: flag it but keep reporting the last good key.
            state_nxt = MULTI;
            multi_nxt = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         keys      <= '0;
         key_code  <= '0;
         key_valid <= 1'b0;
         multi_err <= 1'b0;
      end else begin
         state     <= state_nxt;
         keys      <= keys_nxt;
         key_code  <= code_nxt;
         key_valid <= valid_nxt;
         multi_err <= multi_nxt;
      end
   end

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: ideal switch-matrix keypad plus a frame-level reference model.
module tb_keypad_scanner;

   localparam int SD = 4;
   localparam int DF = 2;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [3:0]  col_in, row_out;
   logic [15:0] keys;
   logic [3:0]  key_code;
   logic        key_valid, multi_err;
   logic [15:0] pressed;

   keypad_scanner #(.SCAN_DIV(SD), .DEBOUNCE_FRAMES(DF)) dut (
      .clk(clk), .rst_n(rst_n), .col_in(col_in), .row_out(row_out),
      .keys(keys), .key_code(key_code), .key_valid(key_valid), .multi_err(multi_err)
   );

   always #5 clk = ~clk;

   // A closed switch pulls its column low only while its row is driven low.
   always_comb begin
      col_in = 4'hF;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++)
            if (pressed[r*4+c] && !row_out[r]) col_in[c] = 1'b0;
   end

   int total = 0;
   int bad   = 0;

   int          n;       // clock edges since reset release
   int          run;     // length of the current run of identical frames
   logic [15:0] frame, prev, m_keys;
   logic [3:0]  m_code;
   logic        m_multi, m_valid;
   int          gcyc = 0;
   int          first_valid;
   int          pulses;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, gcyc);
      end
   endtask

   task automatic model_reset();
      n = 0; run = 0; frame = '0; prev = '0;
      m_keys = '0; m_code = '0; m_multi = 1'b0; m_valid = 1'b0;
   endtask

   // Each row slot reads its row of pressed keys; a frame is four slots.
   task automatic model_update();
      int r;
      m_valid = 1'b0;
      if (n % SD == 0) begin
         r = (n / SD - 1) % 4;
         frame[r*4 +: 4] = pressed[r*4 +: 4];
         if (r == 3) begin
            if (frame == prev) run++;
            else run = 1;
            prev = frame;
            if (run == DF) begin
               case ($countones(frame))
                  0: begin m_keys = '0; m_multi = 1'b0; end
                  1: begin
                     m_valid = (frame != m_keys);
                     m_keys  = frame;
                     for (int i = 0; i < 16; i++) if (frame[i]) m_code = 4'(i);
                     m_multi = 1'b0;
                  end
                  default: m_multi = 1'b1;
               endcase
            end
         end
      end
   endtask

   task automatic compare_outputs();
      logic [3:0] er;
      er = 4'b0001 << ((n / SD) % 4);
      er = ~er;
      check("row_out",   row_out,   er);
      check("keys",      keys,      m_keys);
      check("key_code",  key_code,  m_code);
      check("key_valid", key_valid, m_valid);
      check("multi_err", multi_err, m_multi);
   endtask

   task automatic step();
      @(posedge clk);
      n++;
      gcyc++;
      @(negedge clk);
      model_update();
      compare_outputs();
      if (key_valid) begin
         pulses++;
         if (first_valid < 0) first_valid = gcyc;
      end
   endtask

   task automatic run_slots(input int slots);
      repeat (slots * SD) step();
   endtask

   task automatic do_reset(input int hold);
      rst_n = 1'b0;
      #1;
      model_reset();
      compare_outputs();
      repeat (hold) begin
         @(posedge clk);
         @(negedge clk);
         compare_outputs();
      end
      rst_n = 1'b1;
      n = 0;
   endtask

   initial begin
      int start, kind, hold;
      rst_n = 1'b1;
      pressed = '0;
      first_valid = -1;
      pulses = 0;
      #2;
      do_reset(3);

      // idle scan
      run_slots(16);
      check("idle_pulses", pulses, 0);

      // single key 9 held
      pressed = 16'h0200; start = gcyc; first_valid = -1; pulses = 0;
      run_slots(24);
      check("k9_latency_ok", (first_valid >= 0) && (first_valid - start <= 52), 1);
      check("k9_pulses", pulses, 1);
      check("k9_keys", keys, 16'h0200);
      check("k9_code", key_code, 4'd9);

      // release
      pressed = '0; pulses = 0;
      run_slots(16);
      check("rel_pulses", pulses, 0);
      check("rel_code_hold", key_code, 4'd9);

      // key 9 bouncing frame by frame, then held
      pulses = 0;
      for (int i = 0; i < 5; i++) begin
         pressed = (i % 2 == 0) ? 16'h0200 : 16'h0000;
         run_slots(4);
      end
      check("bounce_pulses", pulses, 0);
      pressed = 16'h0200;
      run_slots(16);
      check("bounce_then_hold", pulses, 1);

      // chord 0+F, release F (differs from held key 9 -> one pulse)
      pressed = 16'h8001; pulses = 0;
      run_slots(16);
      check("chord_multi", multi_err, 1);
      check("chord_keys_hold", keys, 16'h0200);
      pressed = 16'h0001;
      run_slots(16);
      check("chord_rel_multi", multi_err, 0);
      check("chord_rel_keys", keys, 16'h0001);
      check("chord_rel_pulses", pulses, 1);

      // same chord again; leaving MULTI to the held key gives no pulse
      pressed = 16'h8001; pulses = 0;
      run_slots(16);
      pressed = 16'h0001;
      run_slots(16);
      check("chord_same_pulses", pulses, 0);

      pressed = '0;
      run_slots(16);

      // reset in the middle of debouncing key 5
      pressed = 16'h0020;
      run_slots(6);
      do_reset(2);
      pulses = 0;
      run_slots(16);
      check("k5_after_reset", keys, 16'h0020);
      check("k5_pulses", pulses, 1);

      // random patterns with random hold times and occasional resets
      for (int it = 0; it < 60; it++) begin
         kind = $urandom_range(0, 3);
         case (kind)
            0:       pressed = '0;
            3:       pressed = (16'h1 << $urandom_range(0, 15)) | (16'h1 << $urandom_range(0, 15));
            default: pressed = 16'h1 << $urandom_range(0, 15);
         endcase
         hold = $urandom_range(1, 24);
         run_slots(hold);
         if ($urandom_range(0, 11) == 0) begin
            repeat ($urandom_range(0, 3)) step();
            do_reset($urandom_range(1, 3));
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
